addsub_result_fifo: RTL and testbench

//  - Downstream stage of the 16-bit adder/subtractor core. Captures each valid {Z, Overflow} result into a small FIFO.
//  - Presents results to the output pad stage through a valid/ready handshake, so slow off-chip readers do not lose results.
//  - Counts results dropped while the FIFO is full. Optional counter of overflowed results.

---
 rtl/addsub_result_fifo.sv | 94 +++++++++
 tb/tb_addsub_result_fifo.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/addsub_result_fifo.sv
// Result FIFO behind the 16-bit adder/subtractor: first-word fall-through output, saturating drop counter.
// Build option ADDSUB_OVF_COUNT_EN enables the saturating counter of accepted results with Overflow set.
module addsub_result_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_Z,
  input  logic                       in_Overflow,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_Z,
  output logic                       out_Overflow,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic [CNT_W-1:0]           ovf_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [WIDTH:0]       mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [LVL_W-1:0]     level_q;
  logic [CNT_W-1:0]     drop_q;
  logic                 push;
  logic                 pop;
  logic                 drop;
  logic [WIDTH:0]       head;

  assign full      = (level_q == FULL_LVL);
  assign empty     = (level_q == '0);
  assign level     = level_q;
  assign out_valid = !empty;
  assign drop_cnt  = drop_q;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign pop  = out_valid & out_ready;
  assign push = in_valid & (!full | pop);
  assign drop = in_valid & full & !pop;

  assign head         = mem[rd_ptr];
  assign out_Z        = empty ? '0 : head[WIDTH-1:0];
  assign out_Overflow = empty ? 1'b0 : head[WIDTH];

  // Storage is deliberately not reset; pointers and level alone define validity.
  always_ff @(posedge Clock) begin
    if (Reset && push) begin
      mem[wr_ptr] <= {in_Overflow, in_Z};
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      drop_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (drop && (drop_q != '1)) drop_q <= drop_q + 1'b1;
    end
  end

`ifdef ADDSUB_OVF_COUNT_EN
  logic [CNT_W-1:0] ovf_q;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      ovf_q <= '0;
    end else if (push && in_Overflow && (ovf_q != '1)) begin
      ovf_q <= ovf_q + 1'b1;
    end
  end

  assign ovf_cnt = ovf_q;
`else
  assign ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_addsub_result_fifo.sv
// Bench for addsub_result_fifo: directed vector table, hand sequences for multi-cycle corners,
// and randomized traffic checked against a queue-based reference model.
module tb_addsub_result_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef ADDSUB_OVF_COUNT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic                   Clock;
  logic                   Reset;
  logic                   in_valid;
  logic [WIDTH-1:0]       in_Z;
  logic                   in_Overflow;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_Z;
  logic                   out_Overflow;
  logic                   full;
  logic                   empty;
  logic [$clog2(DEPTH):0] level;
  logic [CNT_W-1:0]       drop_cnt;
  logic [CNT_W-1:0]       ovf_cnt;

  addsub_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .Clock(Clock), .Reset(Reset), .in_valid(in_valid), .in_Z(in_Z),
    .in_Overflow(in_Overflow), .out_valid(out_valid), .out_ready(out_ready),
    .out_Z(out_Z), .out_Overflow(out_Overflow), .full(full), .empty(empty),
    .level(level), .drop_cnt(drop_cnt), .ovf_cnt(ovf_cnt)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a queue of {ovf, z} plus two saturating counters.
  logic [WIDTH:0] mq [$];
  int m_drop = 0;
  int m_ovf  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit m_pop, m_push;
    if (!Reset) begin
      mq.delete();
      m_drop = 0;
      m_ovf  = 0;
    end else begin
      m_pop  = (mq.size() > 0) && out_ready;
      m_push = in_valid && ((mq.size() < DEPTH) || m_pop);
      if (in_valid && !m_push && m_drop < CNT_MAX) m_drop++;
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        mq.push_back({in_Overflow, in_Z});
        if (OVF_EN && in_Overflow && m_ovf < CNT_MAX) m_ovf++;
      end
    end
  endtask

  task automatic check_model();
    logic [WIDTH:0] h;
    h = (mq.size() > 0) ? mq[0] : '0;
    check("model out_valid", int'(out_valid), int'(mq.size() > 0));
    check("model out_Z", int'(out_Z), int'(h[WIDTH-1:0]));
    check("model out_Overflow", int'(out_Overflow), int'(h[WIDTH]));
    check("model level", int'(level), mq.size());
    check("model full", int'(full), int'(mq.size() == DEPTH));
    check("model empty", int'(empty), int'(mq.size() == 0));
    check("model drop_cnt", int'(drop_cnt), m_drop);
    check("model ovf_cnt", int'(ovf_cnt), m_ovf);
  endtask

  // Inputs are set just after an edge; the model advances with them and outputs are checked after the next edge.
  task automatic tick();
    model_step();
    @(posedge Clock);
    #1;
    check_model();
  endtask

  task automatic drive(input bit r, input bit iv, input logic [WIDTH-1:0] z, input bit ov, input bit rdy);
    Reset = r; in_valid = iv; in_Z = z; in_Overflow = ov; out_ready = rdy;
  endtask

  typedef struct {
    bit              rst_n;
    bit              iv;
    logic [WIDTH-1:0] z;
    bit              ovf;
    bit              rdy;
    bit              e_valid;
    logic [WIDTH-1:0] e_z;
    bit              e_ovfbit;
    int              e_lvl;
    int              e_drop;
    int              e_ovfcnt;
  } vec_t;

  vec_t tbl [22];
  logic [WIDTH-1:0] got [$];

  initial begin
    //            rst iv  z         ov rdy  valid z_exp     ovb lvl drop ovfc
    tbl[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 0, 0, 0};
    tbl[1]  = '{1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 0, 0, 0};
    tbl[2]  = '{1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0, 1, 0, 0};
    tbl[3]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 0, 0, 0};
    tbl[4]  = '{1'b1, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 1, 0, 0};
    tbl[5]  = '{1'b1, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 2, 0, 0};
    tbl[6]  = '{1'b1, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 3, 0, 0};
    tbl[7]  = '{1'b1, 1'b1, 16'h0004, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 4, 0, 0};
    tbl[8]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0002, 1'b0, 3, 0, 0};
    tbl[9]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0003, 1'b0, 2, 0, 0};
    tbl[10] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0004, 1'b0, 1, 0, 0};
    tbl[11] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 0, 0, 0};
    tbl[12] = '{1'b1, 1'b1, 16'h0011, 1'b1, 1'b0, 1'b1, 16'h0011, 1'b1, 1, 0, 1};
    tbl[13] = '{1'b1, 1'b1, 16'h0022, 1'b0, 1'b0, 1'b1, 16'h0011, 1'b1, 2, 0, 1};
    tbl[14] = '{1'b1, 1'b1, 16'h0033, 1'b1, 1'b0, 1'b1, 16'h0011, 1'b1, 3, 0, 2};
    tbl[15] = '{1'b1, 1'b1, 16'h0044, 1'b0, 1'b0, 1'b1, 16'h0011, 1'b1, 4, 0, 2};
    tbl[16] = '{1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1, 16'h0011, 1'b1, 4, 1, 2};
    tbl[17] = '{1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b1, 16'h0022, 1'b0, 4, 1, 2};
    tbl[18] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0033, 1'b1, 3, 1, 2};
    tbl[19] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0044, 1'b0, 2, 1, 2};
    tbl[20] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'hBEEF, 1'b0, 1, 1, 2};
    tbl[21] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 0, 1, 2};

    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    #1;

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].rst_n, tbl[i].iv, tbl[i].z, tbl[i].ovf, tbl[i].rdy);
      tick();
      check($sformatf("tbl[%0d] out_valid", i), int'(out_valid), int'(tbl[i].e_valid));
      check($sformatf("tbl[%0d] out_Z", i), int'(out_Z), int'(tbl[i].e_z));
      check($sformatf("tbl[%0d] out_Overflow", i), int'(out_Overflow), int'(tbl[i].e_ovfbit));
      check($sformatf("tbl[%0d] level", i), int'(level), tbl[i].e_lvl);
      check($sformatf("tbl[%0d] full", i), int'(full), int'(tbl[i].e_lvl == DEPTH));
      check($sformatf("tbl[%0d] empty", i), int'(empty), int'(tbl[i].e_lvl == 0));
      check($sformatf("tbl[%0d] drop_cnt", i), int'(drop_cnt), tbl[i].e_drop);
      check($sformatf("tbl[%0d] ovf_cnt", i), int'(ovf_cnt), OVF_EN ? tbl[i].e_ovfcnt : 0);
    end

    // Continuous push & pop of 0..9 across pointer wrap.
    got.delete();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, i < 10, WIDTH'(i), 1'b0, 1'b1);
      if (out_valid && out_ready) got.push_back(out_Z);
      tick();
    end
    check("stream count", got.size(), 10);
    for (int i = 0; i < 10 && i < got.size(); i++)
      check($sformatf("stream[%0d]", i), int'(got[i]), i);

    // Drop counter saturation with the FIFO held full.
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1'b1, WIDTH'(16'hA000 + i), 1'b0, 1'b0);
      tick();
    end
    check("drop_cnt saturated", int'(drop_cnt), CNT_MAX);
    check("level while saturating", int'(level), DEPTH);

    // Reset at level 3 overrides simultaneous push and pop.
    drive(1'b1, 1'b0, '0, 1'b0, 1'b1);
    tick();
    check("pre-reset level", int'(level), 3);
    drive(1'b0, 1'b1, 16'h5555, 1'b1, 1'b1);
    tick();
    check("reset level", int'(level), 0);
    check("reset empty", int'(empty), 1);
    check("reset out_valid", int'(out_valid), 0);
    check("reset drop_cnt", int'(drop_cnt), 0);
    check("reset ovf_cnt", int'(ovf_cnt), 0);
    check("reset out_Z", int'(out_Z), 0);

    // Randomized traffic against the reference model, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), WIDTH'($urandom),
            1'($urandom), ($urandom_range(0, 2) != 0));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
